// File: rtl/round_key_seq.sv
// Round-key issue sequencer.
// Captures sixteen round keys into a local bank when a sequence starts, then
// offers them one per accepted transfer over a valid/ready handshake, in
// forward (1..16) or reverse (16..1) order. A one-cycle done pulse follows
// the sixteenth transfer. Abort cancels a sequence and never produces done.
module round_key_seq #(
  parameter int KEY_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             abort,
  input  logic [KEY_W-1:0] r_key1,
  input  logic [KEY_W-1:0] r_key2,
  input  logic [KEY_W-1:0] r_key3,
  input  logic [KEY_W-1:0] r_key4,
  input  logic [KEY_W-1:0] r_key5,
  input  logic [KEY_W-1:0] r_key6,
  input  logic [KEY_W-1:0] r_key7,
  input  logic [KEY_W-1:0] r_key8,
  input  logic [KEY_W-1:0] r_key9,
  input  logic [KEY_W-1:0] r_key10,
  input  logic [KEY_W-1:0] r_key11,
  input  logic [KEY_W-1:0] r_key12,
  input  logic [KEY_W-1:0] r_key13,
  input  logic [KEY_W-1:0] r_key14,
  input  logic [KEY_W-1:0] r_key15,
  input  logic [KEY_W-1:0] r_key16,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [3:0]       round_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [KEY_W-1:0] r_key_s [16];
  logic [KEY_W-1:0] bank_r  [16];
  logic             mode_r;

  logic [1:0]       state_r,     state_n_s;
  logic [KEY_W-1:0] key_out_r,   key_n_s;
  logic             key_valid_r, valid_n_s;
  logic [3:0]       idx_r,       idx_n_s;
  logic             last_r,      last_n_s;
  logic             busy_r,      busy_n_s;
  logic             done_r,      done_n_s;
  logic             capture_s;

  logic [3:0]       nxt_idx_s;
  logic [3:0]       nxt_sel_s;
  logic [KEY_W-1:0] first_key_s;

  assign r_key_s[0]  = r_key1;
  assign r_key_s[1]  = r_key2;
  assign r_key_s[2]  = r_key3;
  assign r_key_s[3]  = r_key4;
  assign r_key_s[4]  = r_key5;
  assign r_key_s[5]  = r_key6;
  assign r_key_s[6]  = r_key7;
  assign r_key_s[7]  = r_key8;
  assign r_key_s[8]  = r_key9;
  assign r_key_s[9]  = r_key10;
  assign r_key_s[10] = r_key11;
  assign r_key_s[11] = r_key12;
  assign r_key_s[12] = r_key13;
  assign r_key_s[13] = r_key14;
  assign r_key_s[14] = r_key15;
  assign r_key_s[15] = r_key16;

  assign key_out   = key_out_r;
  assign key_valid = key_valid_r;
  assign round_idx = idx_r;
  assign last      = last_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Bank slot of the next issue position, and the first key straight from the inputs.
  always_comb begin
    nxt_idx_s = idx_r + 4'd1;
    if (mode_r) begin
      nxt_sel_s = 4'd15 - nxt_idx_s;
    end else begin
      nxt_sel_s = nxt_idx_s;
    end
    if (decrypt) begin
      first_key_s = r_key_s[15];
    end else begin
      first_key_s = r_key_s[0];
    end
  end

  // Sequencer next-state and next-output decode; abort wins over everything.
  always_comb begin
    state_n_s = state_r;
    key_n_s   = key_out_r;
    valid_n_s = key_valid_r;
    idx_n_s   = idx_r;
    last_n_s  = last_r;
    busy_n_s  = busy_r;
    done_n_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          capture_s = 1'b1;
          state_n_s = ISSUE;
          key_n_s   = first_key_s;
          valid_n_s = 1'b1;
          idx_n_s   = 4'd0;
          last_n_s  = 1'b0;
          busy_n_s  = 1'b1;
        end else begin
          valid_n_s = 1'b0;
          busy_n_s  = 1'b0;
          last_n_s  = 1'b0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_n_s = IDLE;
          key_n_s   = {KEY_W{1'b0}};
          valid_n_s = 1'b0;
          idx_n_s   = 4'd0;
          last_n_s  = 1'b0;
          busy_n_s  = 1'b0;
        end else if (key_ready) begin
          if (idx_r == 4'd15) begin
            state_n_s = DONE;
            key_n_s   = {KEY_W{1'b0}};
            valid_n_s = 1'b0;
            idx_n_s   = 4'd0;
            last_n_s  = 1'b0;
            done_n_s  = 1'b1;
          end else begin
            key_n_s   = bank_r[nxt_sel_s];
            idx_n_s   = nxt_idx_s;
            last_n_s  = (nxt_idx_s == 4'd15);
          end
        end else begin
          state_n_s = ISSUE;
        end
      end
      DONE: begin
        state_n_s = IDLE;
        valid_n_s = 1'b0;
        busy_n_s  = 1'b0;
        last_n_s  = 1'b0;
      end
      default: begin
        state_n_s = IDLE;
        key_n_s   = {KEY_W{1'b0}};
        valid_n_s = 1'b0;
        idx_n_s   = 4'd0;
        last_n_s  = 1'b0;
        busy_n_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      key_out_r   <= {KEY_W{1'b0}};
      key_valid_r <= 1'b0;
      idx_r       <= 4'd0;
      last_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      key_out_r   <= key_n_s;
      key_valid_r <= valid_n_s;
      idx_r       <= idx_n_s;
      last_r      <= last_n_s;
      busy_r      <= busy_n_s;
      done_r      <= done_n_s;
    end
  end

  // Key bank and order mode, loaded only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        bank_r[i] <= {KEY_W{1'b0}};
      end
    end else if (capture_s) begin
      mode_r <= decrypt;
      for (int i = 0; i < 16; i++) begin
        bank_r[i] <= r_key_s[i];
      end
    end else begin
      mode_r <= mode_r;
    end
  end

endmodule

// File: tb/tb_round_key_seq.sv
// Self-checking bench for round_key_seq: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_round_key_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic        abort;
  logic        key_ready;
  logic [47:0] keys [16];
  logic [47:0] key_out;
  logic        key_valid;
  logic [3:0]  round_idx;
  logic        last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Reference model: sequence in flight, issue position, captured keys/mode.
  bit          m_active;
  bit          m_done;
  int          m_pos;
  bit          m_mode;
  logic [47:0] m_bank [16];

  always #5 clk = ~clk;

  round_key_seq #(.KEY_W(48)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .abort(abort),
    .r_key1(keys[0]),   .r_key2(keys[1]),   .r_key3(keys[2]),   .r_key4(keys[3]),
    .r_key5(keys[4]),   .r_key6(keys[5]),   .r_key7(keys[6]),   .r_key8(keys[7]),
    .r_key9(keys[8]),   .r_key10(keys[9]),  .r_key11(keys[10]), .r_key12(keys[11]),
    .r_key13(keys[12]), .r_key14(keys[13]), .r_key15(keys[14]), .r_key16(keys[15]),
    .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
    .round_idx(round_idx), .last(last), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] exp_key();
    if (m_mode) return m_bank[15 - m_pos];
    else        return m_bank[m_pos];
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_pos    = 0;
    m_mode   = 1'b0;
    for (int i = 0; i < 16; i++) m_bank[i] = 48'h0;
  endtask

  // Advance the model by one clock edge using the inputs applied at that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (abort) begin
        m_active = 1'b0;
      end else if (key_ready) begin
        if (m_pos == 15) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_pos++;
        end
      end
    end else if (start && !abort) begin
      for (int i = 0; i < 16; i++) m_bank[i] = keys[i];
      m_mode   = decrypt;
      m_active = 1'b1;
      m_pos    = 0;
    end
  endtask

  task automatic compare_all();
    check("key_valid", 48'(key_valid), 48'(m_active));
    check("busy",      48'(busy),      48'(m_active || m_done));
    check("done",      48'(done),      48'(m_done));
    check("last",      48'(last),      48'(m_active && (m_pos == 15)));
    if (m_active) begin
      check("key_out",   key_out,          exp_key());
      check("round_idx", 48'(round_idx),   48'(m_pos));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_ramp_keys();
    for (int i = 0; i < 16; i++) keys[i] = 48'((i + 1) << 4);
  endtask

  task automatic set_random_keys();
    for (int i = 0; i < 16; i++) keys[i] = {16'($urandom), 32'($urandom)};
  endtask

  initial begin
    int          done_at;
    logic [47:0] last_key;

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; key_ready = 1'b0;
    set_ramp_keys();
    model_reset();

    // Reset state.
    step();
    check("rst_key_out", key_out, 48'h0);
    check("rst_round_idx", 48'(round_idx), 48'h0);
    rst = 1'b0;
    step();

    // Forward order, full-rate consumer.
    set_ramp_keys();
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b1;
    step();
    check("fwd_first_key", key_out, 48'h10);
    start = 1'b0;
    done_at = 0;
    for (int c = 2; c <= 19; c++) begin
      step();
      if (done) done_at = c;
      if (last) last_key = key_out;
    end
    check("fwd_done_cycle", 48'(done_at), 48'd17);
    check("fwd_last_key", last_key, 48'h100);

    // Reverse order.
    start = 1'b1; decrypt = 1'b1;
    step();
    check("rev_first_key", key_out, 48'h100);
    start = 1'b0; decrypt = 1'b0;
    for (int c = 2; c <= 19; c++) begin
      step();
      if (last) last_key = key_out;
    end
    check("rev_last_key", last_key, 48'h10);

    // Backpressure 1,0,0 pattern, with start and key changes while busy.
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b1;
    step();
    for (int i = 0; i < 60; i++) begin
      key_ready = (i % 3 == 0);
      start     = (i < 30);
      decrypt   = 1'($urandom);
      if (i == 5) set_random_keys();
      step();
    end
    start = 1'b0;
    key_ready = 1'b1;
    for (int i = 0; i < 50; i++) step();

    // Capture isolation: inputs go to all ones one cycle after start.
    set_ramp_keys();
    start = 1'b1; decrypt = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) keys[i] = 48'hFFFF_FFFF_FFFF;
    step();
    check("iso_second_key", key_out, 48'h20);
    for (int i = 0; i < 18; i++) step();

    // Abort at position 7 together with start, then abort+start in IDLE.
    set_random_keys();
    start = 1'b1; decrypt = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && round_idx != 4'd7; i++) step();
    check("abort_reach7", 48'(round_idx), 48'd7);
    abort = 1'b1; start = 1'b1;
    step();
    check("abort_valid", 48'(key_valid), 48'd0);
    step();
    check("abort_idle_busy", 48'(busy), 48'd0);
    abort = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      decrypt   = 1'($urandom);
      abort     = ($urandom_range(0, 19) == 0);
      key_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) set_random_keys();
      step();
    end
    start = 1'b0; abort = 1'b0; key_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    // Asynchronous reset mid-sequence at position 5.
    set_random_keys();
    start = 1'b1; decrypt = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && round_idx != 4'd5; i++) step();
    check("rst_reach5", 48'(round_idx), 48'd5);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("arst_key_out", key_out, 48'h0);
    check("arst_round_idx", 48'(round_idx), 48'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    set_random_keys();
    start = 1'b1; decrypt = 1'b1;
    step();
    check("post_rst_idx", 48'(round_idx), 48'd0);
    check("post_rst_key", key_out, keys[15]);
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_key_seq.md
ROUND_KEY_SEQ -- requirements
Module: round_key_seq

Interface
REQ-001 SHALL have parameter KEY_W, default 48, round-key width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to capture a key set and begin issuing.
REQ-005 SHALL have port decrypt, input, 1, mode sampled with start: 0 = forward order, 1 = reverse order.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of an issue sequence in progress.
REQ-007 SHALL have ports r_key1 .. r_key16, input, KEY_W each, round keys 1..16 from the key generator.
REQ-008 SHALL have port key_out, output, KEY_W, the registered round key currently offered.
REQ-009 SHALL have port key_valid, output, 1, key_out is valid.
REQ-010 SHALL have port key_ready, input, 1, consumer accepts key_out this cycle.
REQ-011 SHALL have port round_idx, output, 4, issue position 0..15 of the offered key.
REQ-012 SHALL have port last, output, 1, high while the 16th key of a sequence is offered.
REQ-013 SHALL have port busy, output, 1, high in ISSUE and DONE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the 16th key is accepted.

Function
REQ-015 SHALL implement states IDLE, ISSUE and DONE.
REQ-016 SHALL, in IDLE with start=1 and abort=0, capture all 16 keys into an internal bank, latch decrypt, and enter ISSUE on the next edge.
REQ-017 SHALL assert key_valid with key_out = first key in the cycle after start is accepted (1-cycle latency).
REQ-018 SHALL issue bank keys 1,2,...,16 when the latched decrypt=0, and 16,15,...,1 when decrypt=1.
REQ-019 SHALL count round_idx 0..15 in issue order regardless of mode; last = (round_idx==15) && key_valid.
REQ-020 SHALL complete a transfer only on key_valid=1 and key_ready=1 in the same cycle; key_out, round_idx and last stay stable while key_ready=0.
REQ-021 SHALL, on a transfer with round_idx<15, present the next key and increment round_idx on the following edge; back-to-back transfers sustain one key per cycle.
REQ-022 SHALL, on the transfer with round_idx==15, deassert key_valid and enter DONE; done=1 for exactly that DONE cycle, then return to IDLE.
REQ-023 SHALL ignore start while busy=1, including the DONE cycle; bank contents and mode are unchanged.
REQ-024 SHALL ignore changes on r_key1..r_key16 and decrypt after capture; output keys come only from the bank.
REQ-025 SHALL, on abort=1 in ISSUE or DONE, return to IDLE on the next edge with key_valid=0, done=0; no done pulse for an aborted sequence.
REQ-026 SHALL give abort priority over start and over a simultaneous final transfer.
REQ-027 SHALL keep key_valid=0 and done=0 in IDLE; key_ready is don't-care outside ISSUE.

Reset
REQ-028 SHALL, on rst=1, immediately force state IDLE, key_valid=0, done=0, busy=0, last=0, round_idx=0, key_out=0, latched mode=0, bank cleared to 0.
REQ-029 SHALL, on rst asserted mid-sequence, discard the sequence; after release, no output activity until a new start.

Verification
REQ-030 Forward: r_keyN = 48'h0000_0000_00N0 (N=1..16), start with decrypt=0, key_ready=1 -> key_out 0x10,0x20,...,0x100 on 16 consecutive cycles from start+1, last on the 16th, done at start+17.
REQ-031 Reverse: same keys, decrypt=1 -> key_out 0x100 first and 0x10 last; round_idx still 0..15.
REQ-032 Backpressure: key_ready toggled 1,0,0,1,... -> every key appears exactly once in order and stays stable during stalls; done only after the 16th transfer.
REQ-033 Abort/priority: abort at round_idx=7 -> IDLE next cycle, no done; abort with start in IDLE -> stays IDLE; start during ISSUE or DONE -> ignored.
REQ-034 Reset: rst pulsed asynchronously (off clock edge) at round_idx=5 -> all outputs 0 immediately; new start after release issues from round_idx 0 with newly captured keys.
REQ-035 Capture isolation: change all r_key inputs to 48'hFFFF_FFFF_FFFF one cycle after start -> issued keys remain the captured values.
